// File: rtl/axi4_lite_spi_master.sv
// AXI4-Lite register front end driving a single-shot SPI controller for an ADC/DAC.
// Software writes TXDATA to launch a transfer, then polls STATUS for the done flag.
module axi4_lite_spi_master #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            SCK,
  output logic                            SDI,
  output logic                            CONV_CS,
  input  logic                            SDO
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_TAIL} state_t;

  state_t        state_reg;
  logic [DW-1:0] txdata_reg, nbits_reg, sckdiv_reg;
  logic [DW-1:0] div_reg, cnt_reg, rdata_reg, rd_mux;
  logic [30:0]   rx_reg;
  logic [4:0]    bit_reg;
  logic          done_reg, sck_reg, sdi_reg, cs_reg;
  logic          awready_reg, bvalid_reg, arready_reg, rvalid_reg;

  logic [DW-1:0] wmask, tx_new, nbits_new, sckdiv_new, d_eff;
  logic [5:0]    n_eff, n_m1;
  logic [4:0]    bit_m1;
  logic          wr_en, rd_en, start, cnt_last;
  logic          unused_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{S_AXI_WSTRB[gi]}};
    end
  endgenerate

  // The master holds AWVALID/WVALID until the ready pulse, so the write lands on that cycle.
  assign wr_en      = awready_reg && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en      = arready_reg && S_AXI_ARVALID;
  assign tx_new     = (txdata_reg & ~wmask) | (S_AXI_WDATA & wmask);
  assign nbits_new  = (nbits_reg  & ~wmask) | (S_AXI_WDATA & wmask);
  assign sckdiv_new = (sckdiv_reg & ~wmask) | (S_AXI_WDATA & wmask);
  assign start      = wr_en && (S_AXI_AWADDR[3:2] == 2'd0) && (state_reg == ST_IDLE);
  assign n_eff      = (nbits_reg == '0 || nbits_reg > DW'(32)) ? 6'd32 : nbits_reg[5:0];
  assign n_m1       = n_eff - 6'd1;
  assign d_eff      = (sckdiv_reg == '0) ? DW'(1) : sckdiv_reg;
  assign cnt_last   = (cnt_reg == div_reg - DW'(1));
  assign bit_m1     = bit_reg - 5'd1;
  assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_mux = txdata_reg;
      2'd1: rd_mux = DW'({done_reg, rx_reg});
      2'd2: rd_mux = nbits_reg;
      2'd3: rd_mux = sckdiv_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      awready_reg <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_reg && !awready_reg;
      if (wr_en)
        bvalid_reg <= 1'b1;
      else if (S_AXI_BREADY)
        bvalid_reg <= 1'b0;
      arready_reg <= S_AXI_ARVALID && !rvalid_reg && !arready_reg;
      if (rd_en) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_reg  <= ST_IDLE;
      txdata_reg <= '0;
      nbits_reg  <= DW'(24);
      sckdiv_reg <= DW'(2);
      rx_reg     <= '0;
      done_reg   <= 1'b0;
      sck_reg    <= 1'b0;
      sdi_reg    <= 1'b0;
      cs_reg     <= 1'b1;
      cnt_reg    <= '0;
      div_reg    <= DW'(1);
      bit_reg    <= '0;
    end else begin
      if (wr_en && S_AXI_AWADDR[3:2] == 2'd2) nbits_reg  <= nbits_new;
      if (wr_en && S_AXI_AWADDR[3:2] == 2'd3) sckdiv_reg <= sckdiv_new;
      case (state_reg)
        ST_IDLE: begin
          // TXDATA is only accepted here; writes while busy are dropped entirely.
          if (start) begin
            txdata_reg <= tx_new;
            done_reg   <= 1'b0;
            rx_reg     <= '0;
            div_reg    <= d_eff;
            cnt_reg    <= '0;
            bit_reg    <= n_m1[4:0];
            sdi_reg    <= tx_new[n_m1[4:0]];
            cs_reg     <= 1'b0;
            sck_reg    <= 1'b0;
            state_reg  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_last) begin
            cnt_reg <= '0;
            if (!sck_reg) begin
              sck_reg <= 1'b1;
              rx_reg  <= {rx_reg[29:0], SDO};
            end else begin
              sck_reg <= 1'b0;
              if (bit_reg == 5'd0) begin
                state_reg <= ST_TAIL;
              end else begin
                bit_reg <= bit_m1;
                sdi_reg <= txdata_reg[bit_m1];
              end
            end
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
        ST_TAIL: begin
          if (cnt_last) begin
            cnt_reg   <= '0;
            cs_reg    <= 1'b1;
            sdi_reg   <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = awready_reg;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_reg;
  assign SCK           = sck_reg;
  assign SDI           = sdi_reg;
  assign CONV_CS       = cs_reg;
endmodule

// File: tb/tb_axi4_lite_spi_master.sv
// Bench for axi4_lite_spi_master: register table, directed corner cases and random transfers
// checked against a bit-level model of the SPI frame.
module tb_axi4_lite_spi_master;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        sck, sdi, conv_cs, sdo;

  always #5 clk = ~clk;

  axi4_lite_spi_master #(.C_S_AXI_ADDR_WIDTH(4), .C_S_AXI_DATA_WIDTH(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .SCK(sck), .SDI(sdi), .CONV_CS(conv_cs), .SDO(sdo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // SPI-side observer and converter model
  int          rise_cnt = 0;
  int          cs_low = 0;
  logic [31:0] sdi_cap = '0;
  int          cur_n = 24;
  int          sdo_mode = 0;
  logic [31:0] sdo_word = '0;
  int          sdo_idx;
  logic        sdo_bit;

  always @(posedge sck) begin
    rise_cnt = rise_cnt + 1;
    sdi_cap  = {sdi_cap[30:0], sdi};
  end
  always @(posedge clk) if (!conv_cs) cs_low = cs_low + 1;

  always_comb begin
    sdo_idx = cur_n - 1 - rise_cnt;
    sdo_bit = (sdo_idx >= 0 && sdo_idx < 32) ? sdo_word[sdo_idx[4:0]] : 1'b0;
  end
  assign sdo = (sdo_mode == 1) ? sdi : (sdo_mode == 2) ? 1'b1 : sdo_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int t = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && t < 50) begin tick(); t++; end
    check("awready_seen", {31'd0, awready}, 32'd1);
    check("wready_with_awready", {31'd0, wready}, {31'd0, awready});
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_next_cycle", {31'd0, bvalid}, 32'd1);
    check("bresp_okay", {30'd0, bresp}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bvalid_held", {31'd0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] data);
    int t = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && t < 50) begin tick(); t++; end
    if (!arready) check("arready_seen", 32'd0, 32'd1);
    tick();
    arvalid = 1'b0;
    data = rdata;
    if (!rvalid) check("rvalid_next_cycle", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rvalid_held", {31'd0, rvalid}, 32'd1);
      check("rdata_held", rdata, data);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic poll_done(output logic [31:0] st);
    int polls = 0;
    st = '0;
    while (!st[31] && polls < 1000) begin axi_read(4'h4, 0, st); polls++; end
    check("done_within_budget", {31'd0, st[31]}, 32'd1);
  endtask

  task automatic clear_obs(input int n, input int mode, input logic [31:0] word);
    cur_n = n; sdo_mode = mode; sdo_word = word;
    rise_cnt = 0; sdi_cap = '0; cs_low = 0;
  endtask

  // Full transfer against the frame model: N bits MSB-first, 2*D cycles per bit, D tail cycles.
  task automatic run_transfer(input string tag, input int n_raw, input int d_raw,
                              input logic [31:0] tx, input int mode, input logic [31:0] word);
    int neff, deff;
    logic [63:0] m64;
    logic [31:0] mask, exp_rx, st;
    neff = (n_raw == 0 || n_raw > 32) ? 32 : n_raw;
    deff = (d_raw == 0) ? 1 : d_raw;
    m64  = (64'd1 << neff) - 64'd1;
    mask = m64[31:0];
    exp_rx = (mode == 0) ? (word & mask) : (mode == 1) ? (tx & mask) : mask;
    axi_write(4'h8, n_raw, 4'hF, 0);
    axi_write(4'hC, d_raw, 4'hF, 0);
    clear_obs(neff, mode, word);
    axi_write(4'h0, tx, 4'hF, 0);
    poll_done(st);
    check({tag, "_status"}, st, {1'b1, exp_rx[30:0]});
    check({tag, "_sck_edges"}, rise_cnt, neff);
    check({tag, "_sdi_stream"}, sdi_cap & mask, tx & mask);
    check({tag, "_cs_low_cycles"}, cs_low, 2 * neff * deff + deff);
    check({tag, "_idle_pins"}, {29'd0, conv_cs, sck, sdi}, 32'h4);
    $display("xfer %s n=%0d d=%0d tx=%08h mode=%0d status=%08h edges=%0d", tag, n_raw, d_raw, tx, mode, st, rise_cnt);
  endtask

  typedef struct {
    logic        is_write;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, st;
    int edges_after;

    vecs[0] = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0000};
    vecs[1] = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0000};
    vecs[2] = '{1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_0018};
    vecs[3] = '{1'b0, 4'hC, 32'h0, 4'h0, 32'h0000_0002};
    vecs[4] = '{1'b1, 4'h8, 32'hFFFF_FF10, 4'b0001, 32'h0000_0010};
    vecs[5] = '{1'b1, 4'h8, 32'hAABB_CC00, 4'b0110, 32'h00BB_CC10};
    vecs[6] = '{1'b1, 4'hC, 32'h0000_0003, 4'b1111, 32'h0000_0003};
    vecs[7] = '{1'b1, 4'hC, 32'h1234_5678, 4'b1000, 32'h1200_0003};
    vecs[8] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    vecs[9] = '{1'b1, 4'h8, 32'h0000_0018, 4'b1111, 32'h0000_0018};

    repeat (3) tick();
    check("rst_pins", {29'd0, conv_cs, sck, sdi}, 32'h4);
    check("rst_axi_valids", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_write) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
      axi_read(vecs[i].addr, 0, v);
      check($sformatf("reg_vec%0d", i), v, vecs[i].exp);
      $display("vec %0d wr=%0d addr=%h data=%08h strb=%b read=%08h", i, vecs[i].is_write,
               vecs[i].addr, vecs[i].data, vecs[i].strb, v);
    end

    run_transfer("basic", 24, 2, 32'h0050_8000, 0, 32'h0);
    run_transfer("loopback", 24, 2, 32'h0031_0000, 1, 32'h0);
    run_transfer("sdo_high16", 16, 2, 32'h0080_0000, 2, 32'h0);
    run_transfer("n32_d0", 0, 0, 32'hC3A5_0F71, 0, 32'h9ABC_DEF1);
    run_transfer("n1_d1", 1, 1, 32'h0000_0001, 2, 32'h0);

    // Mid-transfer status read and a discarded TXDATA write.
    axi_write(4'h8, 32'd24, 4'hF, 0);
    axi_write(4'hC, 32'd2, 4'hF, 0);
    clear_obs(24, 1, 32'h0);
    axi_write(4'h0, 32'h005A_5A5A, 4'hF, 0);
    repeat (20) tick();
    axi_read(4'h4, 0, st);
    check("mid_done_clear", {31'd0, st[31]}, 32'd0);
    check("mid_cs_low", {31'd0, conv_cs}, 32'd0);
    axi_write(4'h0, 32'h00FF_FFFF, 4'hF, 0);
    axi_write(4'h8, 32'd8, 4'hF, 0);
    poll_done(st);
    check("busy_wr_status", st, 32'h805A_5A5A);
    check("busy_wr_stream", sdi_cap & 32'h00FF_FFFF, 32'h005A_5A5A);
    check("busy_wr_edges", rise_cnt, 24);
    axi_read(4'h0, 0, v);
    check("busy_wr_txdata", v, 32'h005A_5A5A);
    axi_read(4'h4, 0, v);
    check("status_read_keeps_done", v, 32'h805A_5A5A);
    clear_obs(8, 1, 32'h0);
    axi_write(4'h0, 32'h0000_00B4, 4'hF, 0);
    poll_done(st);
    check("deferred_nbits_status", st, 32'h8000_00B4);
    check("deferred_nbits_edges", rise_cnt, 8);

    // Back-pressure on both response channels.
    axi_write(4'hC, 32'h0000_0011, 4'hF, 5);
    axi_read(4'hC, 5, v);
    check("backpressure_rdata", v, 32'h0000_0011);
    $display("backpressure write/read sckdiv=%08h", v);

    // Reset mid-transfer aborts immediately.
    axi_write(4'hC, 32'd2, 4'hF, 0);
    axi_write(4'h8, 32'd24, 4'hF, 0);
    clear_obs(24, 2, 32'h0);
    axi_write(4'h0, 32'h00AB_CDEF, 4'hF, 0);
    repeat (30) tick();
    aresetn = 1'b0;
    tick();
    check("abort_pins", {29'd0, conv_cs, sck, sdi}, 32'h4);
    aresetn = 1'b1;
    edges_after = rise_cnt;
    axi_read(4'h4, 0, v);
    check("abort_status", v, 32'h0);
    axi_read(4'h8, 0, v);
    check("abort_nbits", v, 32'd24);
    axi_read(4'h0, 0, v);
    check("abort_txdata", v, 32'h0);
    repeat (40) tick();
    check("abort_no_more_sck", rise_cnt, edges_after);
    $display("reset abort status/nbits checked");

    for (int k = 0; k < 16; k++) begin
      run_transfer($sformatf("rnd%0d", k), $urandom_range(0, 40), $urandom_range(0, 3),
                   $urandom, $urandom_range(0, 2), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
